covered_gen: RTL and testbench
==============================

# covered_gen

Coverage generator for the SET datapath: scans the 8x8 integer grid (x, y in 1..8) and produces, for each point, the 3-bit `covered` vector (inside circle A/B/C) consumed by the LU logic unit. Downstream, the LU applies the mode function to each vector. The block latches one job of three circles on `en`, streams 64 vectors over a valid/ready handshake, and returns to idle.

## Interface
Parameters:
- `GRID_MAX`, 8, last grid coordinate; scan runs from 1 to `GRID_MAX` on each axis.
- `COORD_W`, 4, width of one centre coordinate and of one radius.

Ports:
- `clk`  in  1  single clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  1  start pulse; sampled only in IDLE.
- `central`  in  24  {Ax, Ay, Bx, By, Cx, Cy}, each 4-bit unsigned, Ax in [23:20].
- `radius`  in  12  {rA, rB, rC}, each 4-bit unsigned, rA in [11:8].
- `busy`  out  1  high from the cycle after accepted `en` until the scan completes.
- `cov_valid_o`  out  1  `covered_o` holds a valid point.
- `cov_ready_i`  in  1  downstream accepts; a transfer occurs when valid and ready are both high.
- `covered_o`  out  3  [2]=inside A, [1]=inside B, [0]=inside C.
- `cov_last_o`  out  1  high with the vector for point (8,8).
- `pt_x_o`, `pt_y_o`  out  4 each  coordinates of the point in `covered_o`.

## Operation
- States: IDLE, SCAN.
- IDLE + `en`=1: latch `central` and `radius`, point counter = (x=1, y=1), output register empty, go to SCAN. `busy`=1 from the next cycle.
- Scan order: x inner (1..8), y outer (1..8). Point (x, y) is index (y-1)*8 + (x-1).
- Per circle: dx = |x - cx|, dy = |y - cy| (4-bit, max 15). d2 = dx*dx + dy*dy (9-bit, max 450). r2 = r*r (8-bit). Covered iff d2 <= r2 (inclusive boundary). Compare at 9 bits, zero-extending r2.
- Single-entry output register. It loads the evaluated current point when it is empty or being transferred this cycle; otherwise it holds. Every load advances the counter.
- While `cov_valid_o`=1 and `cov_ready_i`=0, `covered_o`, `pt_x_o`, `pt_y_o` and `cov_last_o` are held stable.
- After the (8,8) point transfers, the next state is IDLE, with `busy`=0 and `cov_valid_o`=0.
- `en` is ignored in SCAN. Inputs `central` and `radius` may change after `en` is accepted, with no effect on the current scan.
- Reset values: state IDLE, `busy`=0, `cov_valid_o`=0, `covered_o`=0, `cov_last_o`=0, `pt_x_o`=0, `pt_y_o`=0.
- Reset mid-scan: on the next cycle all outputs are at reset values, and no further vectors are emitted until a new `en`.

## Timing
- `en` in cycle 0 (IDLE) -> `busy`=1 in cycle 1, first vector (1,1) valid in cycle 2.
- With `cov_ready_i` held high: one vector per cycle for cycles 2..65, `cov_last_o`=1 in cycle 65, `busy`=0 in cycle 66.
- `en` may be accepted again in cycle 66, giving back-to-back jobs with a 1-cycle IDLE gap.
- Each low cycle of `cov_ready_i` while valid adds exactly one cycle of latency. No vector is dropped or duplicated.
- Latency from `cov_ready_i` rising to transfer is 0 cycles; there is no combinational path from `cov_ready_i` to `cov_valid_o`.

## Test plan
- Circle A at (4,4), rA=2; B and C at (15,15) with r=0; ready always high.
  - Response: exactly 64 transfers in cycles 2..65.
  - `covered_o[2]`=1 on exactly 13 points; bits [1:0] always 0.
  - `cov_last_o` set only at (8,8).
- Same job with `cov_ready_i` toggling at 50%.
  - Response: identical 64-vector sequence.
  - Outputs stable while stalled; `busy` falls one cycle after the last transfer.
- Boundaries:
  - A at (0,0), rA=15 -> all 64 points covered.
  - B at (5,5), rB=0 -> only (5,5) covered.
  - C at (8,1), rC=3 -> (8,4) and (5,1) covered (boundary inclusive), (5,4) not covered.
- `en` pulsed again at cycle 30 of a scan.
  - Response: ignored, 64 vectors only.
  - Changing `central` after acceptance does not alter any output.
- `rst` asserted at cycle 20 of a scan.
  - Response: next cycle `busy`=0, `cov_valid_o`=0, all outputs 0.
  - A new `en` restarts the scan at (1,1).
- Two back-to-back jobs, second `en` in the cycle `busy` falls.
  - Response: second job's first vector valid 2 cycles later, 128 transfers total.

Source files
------------

// File: rtl/covered_gen.sv
// Latches three circles on en, then streams the covered bits for every grid point, x inner, y outer.
// First vector 2 cycles after en, then one per cycle; a single-entry output register holds the vector while ready is low.
module covered_gen #(
  parameter int GRID_MAX = 8,
  parameter int COORD_W  = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   en,
  input  logic [6*COORD_W-1:0]   central,
  input  logic [3*COORD_W-1:0]   radius,
  output logic                   busy,
  output logic                   cov_valid_o,
  input  logic                   cov_ready_i,
  output logic [2:0]             covered_o,
  output logic                   cov_last_o,
  output logic [COORD_W-1:0]     pt_x_o,
  output logic [COORD_W-1:0]     pt_y_o
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] SCAN = 1'b1;

  localparam int D2_W = 2*COORD_W + 1;
  localparam int R2_W = 2*COORD_W;

  localparam logic [COORD_W-1:0] GMAX = COORD_W'(GRID_MAX);
  localparam logic [COORD_W-1:0] ONE  = COORD_W'(1);

  logic [0:0]             state;
  logic [6*COORD_W-1:0]   cen_q;
  logic [3*COORD_W-1:0]   rad_q;
  logic [COORD_W-1:0]     x_q;
  logic [COORD_W-1:0]     y_q;
  logic                   scan_done;

  logic [2:0]             cov_now;
  logic                   pt_last;
  logic                   xfer;
  logic                   load;

  // One distance evaluator per circle; circle A drives bit 2.
  for (genvar g = 0; g < 3; g++) begin : g_circle
    logic [COORD_W-1:0] cx;
    logic [COORD_W-1:0] cy;
    logic [COORD_W-1:0] r;
    logic [COORD_W-1:0] dx;
    logic [COORD_W-1:0] dy;
    logic [D2_W-1:0]    dx2;
    logic [D2_W-1:0]    dy2;
    logic [D2_W-1:0]    d2;
    logic [R2_W-1:0]    r2;

    assign cx  = cen_q[(6-2*g)*COORD_W-1 -: COORD_W];
    assign cy  = cen_q[(5-2*g)*COORD_W-1 -: COORD_W];
    assign r   = rad_q[(3-g)*COORD_W-1 -: COORD_W];
    assign dx  = (x_q >= cx) ? (x_q - cx) : (cx - x_q);
    assign dy  = (y_q >= cy) ? (y_q - cy) : (cy - y_q);
    assign dx2 = D2_W'(dx) * D2_W'(dx);
    assign dy2 = D2_W'(dy) * D2_W'(dy);
    assign d2  = dx2 + dy2;
    assign r2  = R2_W'(r) * R2_W'(r);
    assign cov_now[2-g] = (d2 <= {1'b0, r2});
  end

  assign busy    = (state == SCAN);
  assign pt_last = (x_q == GMAX) && (y_q == GMAX);
  assign xfer    = cov_valid_o && cov_ready_i;
  assign load    = (state == SCAN) && !scan_done && (!cov_valid_o || cov_ready_i);

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= IDLE;
      cen_q       <= '0;
      rad_q       <= '0;
      x_q         <= '0;
      y_q         <= '0;
      scan_done   <= 1'b0;
      cov_valid_o <= 1'b0;
      covered_o   <= '0;
      cov_last_o  <= 1'b0;
      pt_x_o      <= '0;
      pt_y_o      <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (en) begin
            cen_q     <= central;
            rad_q     <= radius;
            x_q       <= ONE;
            y_q       <= ONE;
            scan_done <= 1'b0;
            state     <= SCAN;
          end
        end
        SCAN: begin
          if (load) begin
            cov_valid_o <= 1'b1;
            covered_o   <= cov_now;
            cov_last_o  <= pt_last;
            pt_x_o      <= x_q;
            pt_y_o      <= y_q;
            if (pt_last) begin
              scan_done <= 1'b1;
            end else if (x_q == GMAX) begin
              x_q <= ONE;
              y_q <= y_q + ONE;
            end else begin
              x_q <= x_q + ONE;
            end
          end else if (xfer) begin
            cov_valid_o <= 1'b0;
            cov_last_o  <= 1'b0;
          end
          // The last point has been loaded already, so its transfer ends the job.
          if (xfer && cov_last_o) begin
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_covered_gen.sv
module tb_covered_gen;

  logic        clk;
  logic        rst;
  logic        en;
  logic [23:0] central;
  logic [11:0] radius;
  logic        busy;
  logic        cov_valid_o;
  logic        cov_ready_i;
  logic [2:0]  covered_o;
  logic        cov_last_o;
  logic [3:0]  pt_x_o;
  logic [3:0]  pt_y_o;

  covered_gen #(.GRID_MAX(8), .COORD_W(4)) dut (
    .clk(clk), .rst(rst), .en(en), .central(central), .radius(radius),
    .busy(busy), .cov_valid_o(cov_valid_o), .cov_ready_i(cov_ready_i),
    .covered_o(covered_o), .cov_last_o(cov_last_o),
    .pt_x_o(pt_x_o), .pt_y_o(pt_y_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  localparam logic [23:0] C_BASIC = {4'd4, 4'd4, 4'd15, 4'd15, 4'd15, 4'd15};
  localparam logic [11:0] R_BASIC = {4'd2, 4'd0, 4'd0};
  localparam logic [23:0] C_BND   = {4'd0, 4'd0, 4'd5, 4'd5, 4'd8, 4'd1};
  localparam logic [11:0] R_BND   = {4'd15, 4'd0, 4'd3};

  int n_tests = 0;
  int n_fail  = 0;

  logic [3:0] rec_x   [256];
  logic [3:0] rec_y   [256];
  logic [2:0] rec_cov [256];
  logic       rec_last[256];
  int         rec_cyc [256];
  int         rec_n;
  int         stall_err;
  int         busy_fall;
  int         last_cyc;
  bit         timed_out;

  function automatic logic [2:0] exp_cov(input int x, input int y,
                                         input logic [23:0] c, input logic [11:0] r);
    logic [2:0] v;
    int cx, cy, rr;
    v = '0;
    for (int i = 0; i < 3; i++) begin
      cx = int'(c[23-8*i -: 4]);
      cy = int'(c[19-8*i -: 4]);
      rr = int'(r[11-4*i -: 4]);
      v[2-i] = ((x-cx)*(x-cx) + (y-cy)*(y-cy) <= rr*rr);
    end
    return v;
  endfunction

  // Pulse en for one cycle; returns in cycle 1 of the job.
  task automatic launch(input logic [23:0] c, input logic [11:0] r);
    en = 1'b1;
    central = c;
    radius = r;
    cov_ready_i = 1'b1;
    @(negedge clk);
    en = 1'b0;
  endtask

  // Drives ready (0: always high, 1: high on odd cycles), records transfers,
  // returns at the cycle busy falls or right after asserting rst at rst_cyc.
  task automatic collect(input int rmode, input int en_cyc, input int rst_cyc);
    int cyc;
    logic pv, pr, pl;
    logic [3:0] px, py;
    logic [2:0] pc;
    rec_n = 0; stall_err = 0; busy_fall = -1; last_cyc = -1; timed_out = 0;
    pv = 0; pr = 1; pl = 0; px = '0; py = '0; pc = '0;
    cyc = 1;
    while (cyc < 400) begin
      cov_ready_i = (rmode == 0) ? 1'b1 : (cyc % 2 == 1);
      en = (cyc == en_cyc);
      if (cyc == en_cyc) begin
        central = 24'hFFFFFF;
        radius  = 12'h000;
      end
      if (pv && !pr) begin
        if (!cov_valid_o || covered_o !== pc || pt_x_o !== px ||
            pt_y_o !== py || cov_last_o !== pl)
          stall_err++;
      end
      if (cov_valid_o && cov_ready_i && rec_n < 256) begin
        rec_x[rec_n] = pt_x_o; rec_y[rec_n] = pt_y_o;
        rec_cov[rec_n] = covered_o; rec_last[rec_n] = cov_last_o;
        rec_cyc[rec_n] = cyc;
        if (cov_last_o) last_cyc = cyc;
        rec_n++;
      end
      if (cyc == rst_cyc) begin
        rst = 1'b1;
        return;
      end
      if (!busy && cyc > 1) begin
        busy_fall = cyc;
        return;
      end
      pv = cov_valid_o; pr = cov_ready_i; pl = cov_last_o;
      px = pt_x_o; py = pt_y_o; pc = covered_o;
      @(negedge clk);
      cyc++;
    end
    timed_out = 1;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    repeat (2) @(negedge clk);
    n_tests++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got %b want 0", busy); end
    n_tests++; if (cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL reset_valid got %b want 0", cov_valid_o); end
    n_tests++; if (covered_o !== 3'b000) begin n_fail++; $display("FAIL reset_covered got %b want 000", covered_o); end
    n_tests++; if (cov_last_o !== 1'b0) begin n_fail++; $display("FAIL reset_last got %b want 0", cov_last_o); end
    n_tests++; if (pt_x_o !== 4'd0 || pt_y_o !== 4'd0) begin n_fail++; $display("FAIL reset_pt got %0d,%0d want 0,0", pt_x_o, pt_y_o); end
    rst = 1'b0;
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL idle_after_reset busy=%b valid=%b want 0,0", busy, cov_valid_o); end
  endtask

  task automatic test_basic;
    int cnt_a, bad_bc;
    @(negedge clk);
    launch(C_BASIC, R_BASIC);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL basic_busy_c1 got %b want 1", busy); end
    n_tests++; if (cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL basic_valid_c1 got %b want 0", cov_valid_o); end
    collect(0, -1, -1);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL basic_timeout got 1 want 0"); end
    n_tests++; if (rec_n !== 64) begin n_fail++; $display("FAIL basic_count got %0d want 64", rec_n); end
    n_tests++; if (rec_cyc[0] !== 2 || rec_cyc[63] !== 65) begin n_fail++; $display("FAIL basic_cycles got %0d..%0d want 2..65", rec_cyc[0], rec_cyc[63]); end
    n_tests++; if (busy_fall !== 66) begin n_fail++; $display("FAIL basic_busy_fall got %0d want 66", busy_fall); end
    cnt_a = 0; bad_bc = 0;
    for (int i = 0; i < 64; i++) begin
      if (rec_cov[i][2]) cnt_a++;
      if (rec_cov[i][1:0] != 2'b00) bad_bc++;
      n_tests++;
      if (rec_x[i] !== 4'(i%8+1) || rec_y[i] !== 4'(i/8+1) ||
          rec_cov[i] !== exp_cov(i%8+1, i/8+1, C_BASIC, R_BASIC) || rec_last[i] !== (i == 63)) begin
        n_fail++;
        $display("FAIL basic_vec[%0d] got (%0d,%0d) cov=%b last=%b want (%0d,%0d) cov=%b last=%b", i,
                 rec_x[i], rec_y[i], rec_cov[i], rec_last[i], i%8+1, i/8+1,
                 exp_cov(i%8+1, i/8+1, C_BASIC, R_BASIC), (i == 63));
      end
    end
    n_tests++; if (cnt_a !== 13) begin n_fail++; $display("FAIL basic_a_count got %0d want 13", cnt_a); end
    n_tests++; if (bad_bc !== 0) begin n_fail++; $display("FAIL basic_bc_zero got %0d nonzero want 0", bad_bc); end
  endtask

  task automatic test_stall;
    @(negedge clk);
    launch(C_BASIC, R_BASIC);
    collect(1, -1, -1);
    n_tests++; if (timed_out) begin n_fail++; $display("FAIL stall_timeout got 1 want 0"); end
    n_tests++; if (rec_n !== 64) begin n_fail++; $display("FAIL stall_count got %0d want 64", rec_n); end
    n_tests++; if (stall_err !== 0) begin n_fail++; $display("FAIL stall_stable got %0d changes want 0", stall_err); end
    n_tests++; if (last_cyc !== 129) begin n_fail++; $display("FAIL stall_last_cyc got %0d want 129", last_cyc); end
    n_tests++; if (busy_fall !== last_cyc + 1) begin n_fail++; $display("FAIL stall_busy_fall got %0d want %0d", busy_fall, last_cyc + 1); end
    for (int i = 0; i < 64; i++) begin
      n_tests++;
      if (rec_x[i] !== 4'(i%8+1) || rec_y[i] !== 4'(i/8+1) ||
          rec_cov[i] !== exp_cov(i%8+1, i/8+1, C_BASIC, R_BASIC) || rec_last[i] !== (i == 63)) begin
        n_fail++;
        $display("FAIL stall_vec[%0d] got (%0d,%0d) cov=%b last=%b", i, rec_x[i], rec_y[i], rec_cov[i], rec_last[i]);
      end
    end
  endtask

  task automatic test_boundaries;
    int cnt_a, cnt_b, cnt_c;
    @(negedge clk);
    launch(C_BND, R_BND);
    collect(0, -1, -1);
    n_tests++; if (rec_n !== 64 || timed_out) begin n_fail++; $display("FAIL bnd_count got %0d timeout=%b want 64", rec_n, timed_out); end
    cnt_a = 0; cnt_b = 0; cnt_c = 0;
    for (int i = 0; i < 64; i++) begin
      cnt_a += int'(rec_cov[i][2]);
      cnt_b += int'(rec_cov[i][1]);
      cnt_c += int'(rec_cov[i][0]);
    end
    n_tests++; if (cnt_a !== 64) begin n_fail++; $display("FAIL bnd_a_all got %0d want 64", cnt_a); end
    n_tests++; if (cnt_b !== 1 || rec_cov[36][1] !== 1'b1) begin n_fail++; $display("FAIL bnd_b_single got count=%0d at55=%b want 1,1", cnt_b, rec_cov[36][1]); end
    n_tests++; if (rec_cov[31][0] !== 1'b1) begin n_fail++; $display("FAIL bnd_c_8_4 got %b want 1", rec_cov[31][0]); end
    n_tests++; if (rec_cov[4][0] !== 1'b1) begin n_fail++; $display("FAIL bnd_c_5_1 got %b want 1", rec_cov[4][0]); end
    n_tests++; if (rec_cov[28][0] !== 1'b0) begin n_fail++; $display("FAIL bnd_c_5_4 got %b want 0", rec_cov[28][0]); end
    n_tests++; if (cnt_c !== 11) begin n_fail++; $display("FAIL bnd_c_count got %0d want 11", cnt_c); end
  endtask

  task automatic test_en_ignore;
    int bad;
    @(negedge clk);
    launch(C_BASIC, R_BASIC);
    collect(0, 30, -1);
    n_tests++; if (rec_n !== 64 || busy_fall !== 66) begin n_fail++; $display("FAIL enign_count got %0d fall=%0d want 64,66", rec_n, busy_fall); end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rec_cov[i] !== exp_cov(i%8+1, i/8+1, C_BASIC, R_BASIC)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL enign_vectors got %0d wrong want 0", bad); end
    repeat (3) @(negedge clk);
    n_tests++; if (busy !== 1'b0 || cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL enign_no_restart busy=%b valid=%b want 0,0", busy, cov_valid_o); end
  endtask

  task automatic test_reset_mid;
    @(negedge clk);
    launch(C_BASIC, R_BASIC);
    collect(0, -1, 20);
    @(negedge clk);
    n_tests++; if (busy !== 1'b0 || cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_ctrl busy=%b valid=%b want 0,0", busy, cov_valid_o); end
    n_tests++; if (covered_o !== 3'b000 || cov_last_o !== 1'b0 || pt_x_o !== 4'd0 || pt_y_o !== 4'd0) begin
      n_fail++; $display("FAIL rstmid_data got cov=%b last=%b pt=%0d,%0d want zeros", covered_o, cov_last_o, pt_x_o, pt_y_o);
    end
    rst = 1'b0;
    repeat (2) @(negedge clk);
    n_tests++; if (cov_valid_o !== 1'b0) begin n_fail++; $display("FAIL rstmid_quiet got %b want 0", cov_valid_o); end
    launch(C_BASIC, R_BASIC);
    collect(0, -1, -1);
    n_tests++; if (rec_n !== 64 || rec_cyc[0] !== 2) begin n_fail++; $display("FAIL rstmid_restart_count got %0d first=%0d want 64,2", rec_n, rec_cyc[0]); end
    n_tests++; if (rec_x[0] !== 4'd1 || rec_y[0] !== 4'd1) begin n_fail++; $display("FAIL rstmid_restart_pt got %0d,%0d want 1,1", rec_x[0], rec_y[0]); end
  endtask

  task automatic test_back_to_back;
    int n1, bad;
    @(negedge clk);
    launch(C_BASIC, R_BASIC);
    collect(0, -1, -1);
    n1 = rec_n;
    n_tests++; if (busy_fall !== 66) begin n_fail++; $display("FAIL b2b_fall1 got %0d want 66", busy_fall); end
    launch(C_BND, R_BND);
    n_tests++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_busy2 got %b want 1", busy); end
    collect(0, -1, -1);
    n_tests++; if (rec_cyc[0] !== 2) begin n_fail++; $display("FAIL b2b_first2 got cycle %0d want 2", rec_cyc[0]); end
    n_tests++; if (n1 + rec_n !== 128) begin n_fail++; $display("FAIL b2b_total got %0d want 128", n1 + rec_n); end
    bad = 0;
    for (int i = 0; i < 64; i++)
      if (rec_cov[i] !== exp_cov(i%8+1, i/8+1, C_BND, R_BND)) bad++;
    n_tests++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_job2_vectors got %0d wrong want 0", bad); end
  endtask

  initial begin
    rst = 1'b1;
    en = 1'b0;
    central = '0;
    radius = '0;
    cov_ready_i = 1'b1;
    test_reset();
    test_basic();
    test_stall();
    test_boundaries();
    test_en_ignore();
    test_reset_mid();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
